// File: rtl/fifo_rr_drain_pkg.sv
// Shared types and helpers for the packet-atomic round-robin FIFO drainer.
package fifo_rr_drain_pkg;

  // IDLE: no packet open. BURST: owner's packet open, EOP not yet read.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam int NPORTS_DEF    = 4;
  localparam int DATAWIDTH_DEF = 18;

  // Modular add for operands already below n; keeps port pointers in range
  // when n is not a power of two.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/fifo_rr_drain_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick
  import fifo_rr_drain_pkg::*;
#(
  parameter int NPORTS   = 4,
  parameter int PTRWIDTH = 2
) (
  input  logic [NPORTS-1:0]   req,
  input  logic [PTRWIDTH-1:0] ptr,
  output logic                any,
  output logic [PTRWIDTH-1:0] sel
);

  logic [NPORTS-1:0]   rot;
  logic [PTRWIDTH-1:0] off;

  // Rotate requests right by ptr so the highest-priority port lands at bit 0.
  always_comb begin
    rot = '0;
    for (int j = 0; j < NPORTS; j++) begin
      rot[j] = req[wrap_add(j, int'(ptr), NPORTS)];
    end
  end

  // Priority encode the rotated vector; the lowest set bit wins.
  always_comb begin
    off = '0;
    for (int j = NPORTS - 1; j >= 0; j--) begin
      if (rot[j]) off = PTRWIDTH'(j);
    end
  end

  assign any = |req;
  assign sel = PTRWIDTH'(wrap_add(int'(off), int'(ptr), NPORTS));

endmodule

// File: rtl/fifo_rr_drain.sv
// Packet-atomic round-robin drain of NPORTS zero-latency FIFO read ports into
// one registered write port. A port keeps ownership until its EOP word is read.
module fifo_rr_drain
  import fifo_rr_drain_pkg::*;
#(
  parameter int NPORTS    = NPORTS_DEF,
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int EOPBIT    = DATAWIDTH - 1,
  parameter int PTRWIDTH  = 2
) (
  input  logic                        clk,
  input  logic                        reset_l,
  input  logic [NPORTS-1:0]           fifo_ne,
  input  logic [NPORTS*DATAWIDTH-1:0] fifo_rd_data,
  output logic [NPORTS-1:0]           fifo_re,
  output logic [DATAWIDTH-1:0]        out_data,
  output logic                        out_we,
  input  logic                        out_full,
  output logic [NPORTS-1:0]           grant,
  output logic                        busy
);

  state_e                state_q, state_d;
  logic [PTRWIDTH-1:0]   ptr_q, ptr_d;
  logic [PTRWIDTH-1:0]   owner_q, owner_d;
  logic [NPORTS-1:0]     grant_q, grant_d;
  logic [DATAWIDTH-1:0]  out_data_q, out_data_d;
  logic                  out_we_q, out_we_d;

  logic                  pick_any;
  logic [PTRWIDTH-1:0]   pick_sel;
  logic [PTRWIDTH-1:0]   sel;
  logic                  have;
  logic                  go;
  logic [DATAWIDTH-1:0]  word;

  rr_pick #(
    .NPORTS   (NPORTS),
    .PTRWIDTH (PTRWIDTH)
  ) u_pick (
    .req (fifo_ne),
    .ptr (ptr_q),
    .any (pick_any),
    .sel (pick_sel)
  );

  // Source select and read issue; an open packet locks selection to its owner.
  // Reads are gated by reset so no FIFO is popped while the pipeline is held.
  always_comb begin
    sel     = (state_q == ST_IDLE) ? pick_sel : owner_q;
    have    = (state_q == ST_IDLE) ? pick_any : fifo_ne[owner_q];
    go      = reset_l && !out_full && have;
    word    = fifo_rd_data[int'(sel)*DATAWIDTH +: DATAWIDTH];
    fifo_re = go ? (NPORTS'(1) << sel) : '0;
  end

  // Next state: EOP closes the packet and moves priority past the sender.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    out_data_d = out_data_q;
    out_we_d   = 1'b0;
    if (go) begin
      out_data_d = word;
      out_we_d   = 1'b1;
      if (word[EOPBIT]) begin
        state_d = ST_IDLE;
        ptr_d   = PTRWIDTH'(wrap_add(int'(sel), 1, NPORTS));
        grant_d = '0;
      end else begin
        state_d = ST_BURST;
        owner_d = sel;
        grant_d = NPORTS'(1) << sel;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      out_data_q <= '0;
      out_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      out_data_q <= out_data_d;
      out_we_q   <= out_we_d;
    end
  end

  assign out_data = out_data_q;
  assign out_we   = out_we_q;
  assign grant    = grant_q;
  assign busy     = (state_q == ST_BURST);

  // Reading an empty port would mean the selection logic is broken.
  a_no_empty_read: assert property (@(posedge clk) disable iff (!reset_l)
    (fifo_re & ~fifo_ne) == '0);

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Bench for fifo_rr_drain: per-port source queues, a packet-level reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_fifo_rr_drain;
  localparam int N  = 4;
  localparam int DW = 18;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    fifo_ne, fifo_re, grant;
  logic [N*DW-1:0] fifo_rd_data;
  logic [DW-1:0]   out_data;
  logic            out_we, out_full, busy;

  logic [2:0]      ne3, re3, grant3;
  logic [3*DW-1:0] rd3;
  logic [DW-1:0]   out_data3;
  logic            out_we3, busy3;

  fifo_rr_drain #(.NPORTS(N), .DATAWIDTH(DW), .EOPBIT(DW-1), .PTRWIDTH(PW)) u_dut (
    .clk(clk), .reset_l(reset_l), .fifo_ne(fifo_ne), .fifo_rd_data(fifo_rd_data),
    .fifo_re(fifo_re), .out_data(out_data), .out_we(out_we), .out_full(out_full),
    .grant(grant), .busy(busy));

  fifo_rr_drain #(.NPORTS(3), .DATAWIDTH(DW), .EOPBIT(DW-1), .PTRWIDTH(2)) u_dut3 (
    .clk(clk), .reset_l(reset_l), .fifo_ne(ne3), .fifo_rd_data(rd3),
    .fifo_re(re3), .out_data(out_data3), .out_we(out_we3), .out_full(1'b0),
    .grant(grant3), .busy(busy3));

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q [N][$];
  logic [DW-1:0] olog [$];
  logic [N-1:0]  avail;
  int            pop_port = -1;
  int            seq = 0;
  bit            rnd = 0;

  // Reference model state: open packet owner (-1 = none), next-priority port.
  int            m_owner, m_ptr;
  logic          exp_we;
  logic [DW-1:0] exp_data;
  logic [N-1:0]  exp_grant;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word layout: eop | port[3:0] | sequence[12:0]
  function automatic logic [DW-1:0] mk(input int p, input bit eop);
    logic [3:0]  pp;
    logic [12:0] ss;
    seq++;
    pp = p[3:0];
    ss = seq[12:0];
    return {eop, pp, ss};
  endfunction

  function automatic int port_of(input logic [DW-1:0] w);
    return int'(w[16:13]);
  endfunction

  task automatic push_pkt(input int p, input int len);
    for (int k = 0; k < len; k++) q[p].push_back(mk(p, k == len - 1));
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      fifo_ne[i] = (q[i].size() != 0) && avail[i];
      fifo_rd_data[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : '0;
    end
  endtask

  // Apply the read the model predicted for the edge just taken, then new stimulus.
  task automatic step();
    int p, len;
    @(posedge clk);
    #1;
    if (pop_port >= 0) q[pop_port].delete(0);
    pop_port = -1;
    if (rnd) begin
      for (int i = 0; i < N; i++) avail[i] = ($urandom_range(0, 4) != 0);
      out_full = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) begin
        p   = $urandom_range(0, N - 1);
        len = $urandom_range(1, 4);
        if (q[p].size() < 12) push_pkt(p, len);
      end
    end
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  // Compare process: check registered outputs against last prediction, then
  // predict this cycle's read from the packet/round-robin rules.
  always @(negedge clk) begin : cmp
    int sel;
    bit found;
    bit go;
    logic [N-1:0] exp_re;
    if (!reset_l) begin
      m_owner = -1; m_ptr = 0; exp_we = 1'b0; exp_data = '0; exp_grant = '0;
    end
    chk("out_we", out_we, exp_we);
    chk("out_data", out_data, exp_data);
    chk("grant", grant, exp_grant);
    chk("busy", busy, m_owner >= 0);
    if (out_we === 1'b1) olog.push_back(out_data);
    found = 0;
    sel = 0;
    if (reset_l) begin
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++)
          if (!found && fifo_ne[(m_ptr + k) % N]) begin found = 1; sel = (m_ptr + k) % N; end
      end else if (fifo_ne[m_owner]) begin
        found = 1; sel = m_owner;
      end
    end
    go = found && !out_full;
    exp_re = go ? (4'b0001 << sel) : 4'b0000;
    chk("fifo_re", fifo_re, exp_re);
    exp_we = go;
    pop_port = -1;
    if (go) begin
      exp_data = q[sel][0];
      pop_port = sel;
      if (exp_data[DW-1]) begin
        m_owner = -1; m_ptr = (sel + 1) % N; exp_grant = '0;
      end else begin
        m_owner = sel; exp_grant = 4'b0001 << sel;
      end
    end
  end

  int base;
  int ord1 [5]  = '{3, 0, 1, 2, 3};
  int ord2 [16] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3};
  int ord3 [5]  = '{1, 1, 1, 3, 0};
  logic [DW-1:0] w4 [4];

  initial begin
    avail = '1; out_full = 1'b0; ne3 = '0;
    for (int i = 0; i < 3; i++) rd3[i*DW +: DW] = mk(i, 1'b1);
    drive();
    mid();
    chk("rst_out_data", out_data, '0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    reset_l = 1'b1;
    ne3 = 3'b111;

    // Single-word packets on 3 ports: strict 0,1,2,0,1,2 with pointer wrap.
    for (int k = 0; k < 6; k++) begin
      mid();
      chk("t5_re", re3, 3'b001 << (k % 3));
      chk("t5_grant", grant3, 3'b000);
      chk("t5_busy", busy3, 1'b0);
      if (k > 0) begin
        chk("t5_we", out_we3, 1'b1);
        chk("t5_port", port_of(out_data3), (k - 1) % 3);
      end
      step();
    end
    ne3 = '0;
    step();

    // Port 2 alone, 3-word packet.
    push_pkt(2, 3); drive();
    mid(); chk("t1_re0", fifo_re, 4'b0100);
    step();
    mid(); chk("t1_grant1", grant, 4'b0100); chk("t1_busy1", busy, 1'b1);
    step();
    mid(); chk("t1_grant2", grant, 4'b0100); chk("t1_re2", fifo_re, 4'b0100);
    step();
    mid(); chk("t1_grant3", grant, 4'b0000); chk("t1_busy3", busy, 1'b0);
    chk("t1_we3", out_we, 1'b1); chk("t1_eop", out_data[DW-1], 1'b1);
    step();
    // Pointer now 3: port 3 goes first.
    for (int p = 0; p < N; p++) push_pkt(p, 1);
    push_pkt(3, 1);
    drive(); base = olog.size();
    run(5); mid();
    chk("t1_cnt", olog.size() - base, 5);
    for (int k = 0; k < 5; k++) chk("t1_order", port_of(olog[base + k]), ord1[k]);
    step();

    // All ports, two 2-word packets each: fixed order, no bubbles.
    for (int p = 0; p < N; p++) begin push_pkt(p, 2); push_pkt(p, 2); end
    drive(); base = olog.size();
    run(16); mid();
    chk("t2_cnt", olog.size() - base, 16);
    for (int k = 0; k < 16; k++) chk("t2_order", port_of(olog[base + k]), ord2[k]);
    chk("t2_empty", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
    step();

    // Owner runs dry mid-packet while others request: stall holding grant.
    push_pkt(1, 3); drive(); base = olog.size();
    step();
    avail[1] = 1'b0; push_pkt(0, 1); push_pkt(3, 1); drive();
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("t3_re", fifo_re, 4'b0000);
      chk("t3_grant", grant, 4'b0010);
      step();
    end
    avail[1] = 1'b1; drive();
    run(5); mid();
    chk("t3_cnt", olog.size() - base, 5);
    for (int k = 0; k < 5; k++) chk("t3_order", port_of(olog[base + k]), ord3[k]);
    step();

    // Backpressure mid-packet: nothing lost or duplicated.
    push_pkt(2, 4);
    for (int k = 0; k < 4; k++) w4[k] = q[2][k];
    drive(); base = olog.size();
    step();
    out_full = 1'b1; drive();
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("t4_re", fifo_re, 4'b0000);
      if (k > 0) chk("t4_we", out_we, 1'b0);
      step();
    end
    out_full = 1'b0; drive();
    run(4); mid();
    chk("t4_cnt", olog.size() - base, 4);
    for (int k = 0; k < 4; k++) chk("t4_word", olog[base + k], w4[k]);
    step();

    // Reset during BURST aborts and restarts arbitration at port 0.
    push_pkt(3, 3); drive();
    step();
    reset_l = 1'b0; drive();
    mid();
    chk("t6_busy", busy, 1'b0); chk("t6_grant", grant, 4'b0000);
    chk("t6_we", out_we, 1'b0); chk("t6_re", fifo_re, 4'b0000);
    step();
    reset_l = 1'b1;
    q[3].delete();
    for (int p = 0; p < N; p++) push_pkt(p, 1);
    drive(); base = olog.size();
    run(4); mid();
    chk("t6_cnt", olog.size() - base, 4);
    for (int k = 0; k < 4; k++) chk("t6_order", port_of(olog[base + k]), k);
    step();

    // Randomized traffic, empties and backpressure against the model.
    rnd = 1;
    run(3000);
    rnd = 0; avail = '1; out_full = 1'b0; drive();
    run(200); mid();
    chk("rand_drained", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
